// File: rtl/cod2outof5_barcode_tx_pkg.sv
// rtl/cod2outof5_barcode_tx_pkg.sv - shared types, bar patterns and code helpers for the 2-of-5 transmitter
package cod2outof5_pkg;

    typedef enum logic [2:0] {
        IDLE,
        QUIET_PRE,
        START,
        DATA,
        CHECK,
        STOP,
        QUIET_POST
    } state_e;

    typedef enum logic [1:0] {
        SEL_NARROW,
        SEL_WIDE,
        SEL_QUIET
    } width_sel_e;

    // Bar widths in emission order, 1 = wide; left-aligned into the 5-bit pattern register
    localparam logic [2:0] START_BARS = 3'b110;
    localparam logic [2:0] STOP_BARS  = 3'b101;

    function automatic logic [4:0] digit_to_code(input logic [3:0] d);
        case (d)
            4'd0:    digit_to_code = 5'b00110;
            4'd1:    digit_to_code = 5'b10001;
            4'd2:    digit_to_code = 5'b01001;
            4'd3:    digit_to_code = 5'b11000;
            4'd4:    digit_to_code = 5'b00101;
            4'd5:    digit_to_code = 5'b10100;
            4'd6:    digit_to_code = 5'b01100;
            4'd7:    digit_to_code = 5'b00011;
            4'd8:    digit_to_code = 5'b10010;
            4'd9:    digit_to_code = 5'b01010;
            default: digit_to_code = 5'b00000;
        endcase
    endfunction

    // Both operands must already be in 0..9
    function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        add_mod10 = (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
    endfunction

endpackage

// File: rtl/cod2outof5_barcode_tx_if.sv
// rtl/cod2outof5_barcode_tx_if.sv - digit input stream of the 2-of-5 barcode transmitter
interface cod2outof5_barcode_tx_if;
    logic [3:0] digit_i;
    logic       digit_valid;
    logic       digit_last;
    logic       digit_ready;

    modport master (output digit_i, digit_valid, digit_last, input digit_ready);
    modport slave  (input digit_i, digit_valid, digit_last, output digit_ready);
endinterface

// File: rtl/cod2outof5_barcode_tx_bar_element_timer.sv
// rtl/cod2outof5_barcode_tx_bar_element_timer.sv - times one bar+space element or one quiet zone
module bar_element_timer
    import cod2outof5_pkg::*;
#(
    parameter int NARROW_TICKS = 1,
    parameter int WIDE_TICKS   = 3,
    parameter int QUIET_TICKS  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  width_sel_e sel_i,
    output logic       bar_o,
    output logic       elem_done_o
);
    localparam int MAX_TICKS = (WIDE_TICKS > QUIET_TICKS) ? WIDE_TICKS : QUIET_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bar_q, bar_d;

    // Idle timer sits at cnt=0 in the space phase, so done stays high until the next load
    assign elem_done_o = !bar_q && (cnt_q == '0);
    assign bar_o       = bar_q;

    always_comb begin
        cnt_d = cnt_q;
        bar_d = bar_q;
        if (load_i) begin
            case (sel_i)
                SEL_WIDE:   begin bar_d = 1'b1; cnt_d = CW'(WIDE_TICKS - 1);   end
                SEL_NARROW: begin bar_d = 1'b1; cnt_d = CW'(NARROW_TICKS - 1); end
                default:    begin bar_d = 1'b0; cnt_d = CW'(QUIET_TICKS - 1);  end
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else if (bar_q) begin
            bar_d = 1'b0;
            cnt_d = CW'(NARROW_TICKS - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            bar_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bar_q <= bar_d;
        end
    end
endmodule

// File: rtl/cod2outof5_barcode_tx.sv
// rtl/cod2outof5_barcode_tx.sv - Standard 2-of-5 barcode serialiser; CODE2OF5_CHECKDIGIT_EN adds a mod-10 check digit
module cod2outof5_barcode_tx
    import cod2outof5_pkg::*;
#(
    parameter int NARROW_TICKS = 1,
    parameter int WIDE_TICKS   = 3,
    parameter int QUIET_TICKS  = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    cod2outof5_barcode_tx_if.slave        dig,
    output logic                          bar_out,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          err
);
    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [4:0] code_q, code_d, new_code;
    logic       last_q, last_d, wait_q, wait_d, err_q, err_d;
    logic       buf_full_q, buf_full_d, buf_last_q, buf_last_d;
    logic [3:0] buf_digit_q, buf_digit_d, cur_digit;
    logic       load, elem_done, take, start_elem, step;
    width_sel_e sel;
    logic       accept, bad_digit, push_ok, avail, cur_last, seg_last;

`ifdef CODE2OF5_CHECKDIGIT_EN
    logic [3:0] acc_q, acc_d, weighted, check_digit;
    logic       odd_q, odd_d;

    assign weighted    = odd_q ? add_mod10(add_mod10(cur_digit, cur_digit), cur_digit) : cur_digit;
    assign check_digit = (acc_q == 4'd0) ? 4'd0 : 4'd10 - acc_q;
`endif

    assign dig.digit_ready = !buf_full_q;
    assign accept    = dig.digit_valid && !buf_full_q;
    assign bad_digit = dig.digit_i > 4'd9;
    assign push_ok   = accept && !bad_digit;
    // An empty buffer is bypassed so a digit arriving during underrun starts on the next cycle
    assign avail     = buf_full_q || push_ok;
    assign cur_digit = buf_full_q ? buf_digit_q : dig.digit_i;
    assign cur_last  = buf_full_q ? buf_last_q : dig.digit_last;
    assign seg_last  = elem_done &&
                       (idx_q == (((state_q == START) || (state_q == STOP)) ? 3'd2 : 3'd4));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        code_d     = code_q;
        last_d     = last_q;
        wait_d     = wait_q;
        err_d      = accept && bad_digit;
        load       = 1'b0;
        sel        = SEL_NARROW;
        take       = 1'b0;
        start_elem = 1'b0;
        step       = 1'b0;
        new_code   = code_q;
`ifdef CODE2OF5_CHECKDIGIT_EN
        acc_d      = acc_q;
        odd_d      = odd_q;
`endif
        case (state_q)
            IDLE: begin
                last_d = 1'b0;
                wait_d = 1'b0;
`ifdef CODE2OF5_CHECKDIGIT_EN
                acc_d  = 4'd0;
                odd_d  = 1'b1;
`endif
                if (buf_full_q) begin
                    state_d = QUIET_PRE;
                    load    = 1'b1;
                    sel     = SEL_QUIET;
                end
            end
            QUIET_PRE: begin
                if (elem_done) begin
                    state_d    = START;
                    start_elem = 1'b1;
                    new_code   = {START_BARS, 2'b00};
                end
            end
            START, DATA: begin
                if (wait_q || seg_last) begin
                    if (last_q) begin
                        wait_d     = 1'b0;
                        start_elem = 1'b1;
`ifdef CODE2OF5_CHECKDIGIT_EN
                        state_d    = CHECK;
                        new_code   = digit_to_code(check_digit);
`else
                        state_d    = STOP;
                        new_code   = {STOP_BARS, 2'b00};
`endif
                    end else if (avail) begin
                        take       = 1'b1;
                        wait_d     = 1'b0;
                        state_d    = DATA;
                        last_d     = cur_last;
                        start_elem = 1'b1;
                        new_code   = digit_to_code(cur_digit);
`ifdef CODE2OF5_CHECKDIGIT_EN
                        acc_d      = add_mod10(acc_q, weighted);
                        odd_d      = !odd_q;
`endif
                    end else if (!wait_q) begin
                        state_d = DATA;
                        wait_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end else if (elem_done) begin
                    step = 1'b1;
                end
            end
            CHECK, STOP: begin
                if (seg_last && (state_q == CHECK)) begin
                    state_d    = STOP;
                    start_elem = 1'b1;
                    new_code   = {STOP_BARS, 2'b00};
                end else if (seg_last) begin
                    state_d = QUIET_POST;
                    load    = 1'b1;
                    sel     = SEL_QUIET;
                end else if (elem_done) begin
                    step = 1'b1;
                end
            end
            QUIET_POST: begin
                if (elem_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start_elem) begin
            load   = 1'b1;
            sel    = new_code[4] ? SEL_WIDE : SEL_NARROW;
            code_d = new_code;
            idx_d  = 3'd0;
        end
        if (step) begin
            load   = 1'b1;
            sel    = code_q[3] ? SEL_WIDE : SEL_NARROW;
            code_d = {code_q[3:0], 1'b0};
            idx_d  = idx_q + 3'd1;
        end
        // A dropped digit that closes the frame still ends the data section
        if (accept && bad_digit && dig.digit_last &&
            ((state_q == QUIET_PRE) || (state_q == START) || (state_q == DATA))) begin
            last_d = 1'b1;
        end

        buf_full_d  = buf_full_q ? !take : (push_ok && !take);
        buf_digit_d = push_ok ? dig.digit_i : buf_digit_q;
        buf_last_d  = push_ok ? dig.digit_last : buf_last_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            code_q      <= 5'd0;
            last_q      <= 1'b0;
            wait_q      <= 1'b0;
            err_q       <= 1'b0;
            buf_full_q  <= 1'b0;
            buf_last_q  <= 1'b0;
            buf_digit_q <= 4'd0;
`ifdef CODE2OF5_CHECKDIGIT_EN
            acc_q       <= 4'd0;
            odd_q       <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            code_q      <= code_d;
            last_q      <= last_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            buf_full_q  <= buf_full_d;
            buf_last_q  <= buf_last_d;
            buf_digit_q <= buf_digit_d;
`ifdef CODE2OF5_CHECKDIGIT_EN
            acc_q       <= acc_d;
            odd_q       <= odd_d;
`endif
        end
    end

    bar_element_timer #(
        .NARROW_TICKS (NARROW_TICKS),
        .WIDE_TICKS   (WIDE_TICKS),
        .QUIET_TICKS  (QUIET_TICKS)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .sel_i       (sel),
        .bar_o       (bar_out),
        .elem_done_o (elem_done)
    );

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == QUIET_POST) && elem_done;
    assign err        = err_q;
endmodule

// File: tb/tb_cod2outof5_barcode_tx.sv
// tb/tb_cod2outof5_barcode_tx.sv - scoreboard bench for the 2-of-5 barcode transmitter
module tb_cod2outof5_barcode_tx;
    localparam int NARROW = 1;
    localparam int WIDE   = 3;
    localparam int QUIET  = 2;
`ifdef CODE2OF5_CHECKDIGIT_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bar_out, busy, frame_done, err;

    cod2outof5_barcode_tx_if ifc ();

    cod2outof5_barcode_tx #(
        .NARROW_TICKS (NARROW),
        .WIDE_TICKS   (WIDE),
        .QUIET_TICKS  (QUIET)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dig        (ifc),
        .bar_out    (bar_out),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // hi = expected bar width (0 marks frame end); gap = zeros expected before it (-1: underrun, long)
    typedef struct {
        int hi;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   err_cnt  = 0;
    int   next_gap = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic logic [4:0] code_of(input int d);
        case (d)
            0: return 5'b00110;
            1: return 5'b10001;
            2: return 5'b01001;
            3: return 5'b11000;
            4: return 5'b00101;
            5: return 5'b10100;
            6: return 5'b01100;
            7: return 5'b00011;
            8: return 5'b10010;
            default: return 5'b01010;
        endcase
    endfunction

    function automatic void push_bars(input logic [4:0] pat, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.hi  = pat[4-i] ? WIDE : NARROW;
            e.gap = next_gap;
            exp_q.push_back(e);
            next_gap = NARROW;
        end
    endfunction

    function automatic void begin_frame();
        next_gap = QUIET;
        push_bars(5'b11000, 3);
    endfunction

    function automatic void end_frame(input int check_digit);
        exp_t e;
        if (CHECK_EN) push_bars(code_of(check_digit), 5);
        push_bars(5'b10100, 3);
        e.hi  = 0;
        e.gap = NARROW + QUIET;
        exp_q.push_back(e);
    endfunction

    task automatic send(input logic [3:0] d, input logic last);
        int  n;
        logic rdy;
        n = 0;
        ifc.digit_i     = d;
        ifc.digit_last  = last;
        ifc.digit_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = ifc.digit_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 500);
        #1;
        ifc.digit_valid = 1'b0;
        if (!rdy) chk("send accepted", 0, 1);
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: turns bar_out into bar widths/gaps and pops the scoreboard
    initial begin
        int   run_hi, run_lo, exp_hi;
        logic prev_bar, prev_busy;
        exp_t e;
        run_hi = 0; run_lo = 0; exp_hi = 0; prev_bar = 1'b0; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_hi = 0; run_lo = 0; prev_bar = 1'b0; prev_busy = 1'b0;
            end else begin
                if (err) err_cnt++;
                if (busy) begin
                    if (!prev_busy) begin run_hi = 0; run_lo = 0; end
                    if (bar_out) begin
                        if (!prev_bar) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected bar queue size", 0, 1);
                            end else begin
                                e = exp_q.pop_front();
                                exp_hi = e.hi;
                                if (e.gap < 0) chk("underrun gap", (run_lo >= 5) ? 5 : run_lo, 5);
                                else chk("space before bar", run_lo, e.gap);
                            end
                            run_hi = 0;
                        end
                        run_hi++;
                    end else begin
                        if (prev_bar) begin
                            chk("bar width", run_hi, exp_hi);
                            run_lo = 0;
                        end
                        run_lo++;
                    end
                    if (frame_done) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected frame_done queue size", 0, 1);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_done position", e.hi, 0);
                            chk("closing space", run_lo, e.gap);
                        end
                    end
                end else begin
                    chk("idle bar_out", int'(bar_out), 0);
                end
                prev_bar  = bar_out;
                prev_busy = busy;
            end
        end
    end

    initial begin
        ifc.digit_i     = 4'd0;
        ifc.digit_last  = 1'b0;
        ifc.digit_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset bar_out", int'(bar_out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_done", int'(frame_done), 0);
        chk("reset err", int'(err), 0);
        chk("reset digit_ready", int'(ifc.digit_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single digit 1
        err_cnt = 0;
        begin_frame(); push_bars(code_of(1), 5); end_frame(7);
        send(4'd1, 1'b1);
        chk("ready low while buffered", int'(ifc.digit_ready), 0);
        wait_frame("t1 frame complete");
        chk("t1 err count", err_cnt, 0);

        // back-to-back 3,8,0
        err_cnt = 0;
        begin_frame(); push_bars(code_of(3), 5); push_bars(code_of(8), 5); push_bars(code_of(0), 5); end_frame(3);
        send(4'd3, 1'b0); send(4'd8, 1'b0); send(4'd0, 1'b1);
        wait_frame("t2 frame complete");
        chk("t2 err count", err_cnt, 0);
        chk("t2 ready after frame", int'(ifc.digit_ready), 1);

        // invalid digit mid-frame is dropped
        err_cnt = 0;
        begin_frame(); push_bars(code_of(1), 5); push_bars(code_of(5), 5); end_frame(2);
        send(4'd1, 1'b0); send(4'hC, 1'b0); send(4'd5, 1'b1);
        wait_frame("t3 frame complete");
        chk("t3 err count", err_cnt, 1);

        // underrun between 2 and 7
        err_cnt = 0;
        begin_frame(); push_bars(code_of(2), 5); next_gap = -1; push_bars(code_of(7), 5); end_frame(7);
        send(4'd2, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("t4 bar_out during underrun", int'(bar_out), 0);
        send(4'd7, 1'b1);
        wait_frame("t4 frame complete");
        chk("t4 err count", err_cnt, 1);

        // reset during DATA, then a clean frame
        err_cnt = 0;
        begin_frame(); push_bars(code_of(4), 5); end_frame(8);
        send(4'd4, 1'b1);
        repeat (16) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t5 bar_out after reset", int'(bar_out), 0);
        chk("t5 busy after reset", int'(busy), 0);
        chk("t5 ready after reset", int'(ifc.digit_ready), 1);
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        begin_frame(); push_bars(code_of(9), 5); end_frame(3);
        send(4'd9, 1'b1);
        wait_frame("t5 frame complete");
        chk("t5 err count", err_cnt, 0);

        // digits 1,2,3 (check digit 6 when enabled)
        err_cnt = 0;
        begin_frame(); push_bars(code_of(1), 5); push_bars(code_of(2), 5); push_bars(code_of(3), 5); end_frame(6);
        send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd3, 1'b1);
        wait_frame("t6 frame complete");
        chk("t6 err count", err_cnt, 0);
        chk("final busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
